// File: rtl/scan_pkg.sv
// Shared types and constants for the scan test controller and its shift-phase counter.
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    localparam int CHAIN_LEN_DEFAULT = 2;
    localparam int FAULT_CNT_W       = 8;

endpackage

// File: rtl/scan_shift_counter.sv
// Down-counter timing the LOAD and UNLOAD shift phases; holds at zero instead of wrapping.
module scan_shift_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scan_test_controller.sv
// Applies one scan pattern per start: shift in, one functional capture, shift out, compare
// against the fault-free response and keep a saturating count of failing patterns.
module scan_test_controller
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CHAIN_LEN-1:0]   pattern,
    input  logic [CHAIN_LEN-1:0]   expected,
    input  logic                   clear_count,
    input  logic                   scan_out,
    output logic                   scan_enable,
    output logic                   scan_in,
    output logic                   busy,
    output logic                   done,
    output logic [CHAIN_LEN-1:0]   response,
    output logic                   pass,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    state_t               state;
    logic [CHAIN_LEN-1:0] pat_sr;
    logic [CHAIN_LEN-1:0] exp_lat;
    logic [CHAIN_LEN-1:0] resp_next;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;

    always_comb begin
        cnt_load  = ((state == IDLE) && start) || (state == CAPTURE);
        cnt_dec   = ((state == LOAD) || (state == UNLOAD)) && !cnt_zero;
        // First bit unloaded is the last chain flop, so it ends up in the MSB after all shifts.
        resp_next    = response << 1;
        resp_next[0] = scan_out;
    end

    scan_shift_counter #(
        .W(CNT_W)
    ) u_shift_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (CNT_W'(CHAIN_LEN - 1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pat_sr      <= '0;
            exp_lat     <= '0;
            scan_enable <= 1'b0;
            scan_in     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            response    <= '0;
            fault_count <= '0;
        end else begin
            // A clear on the same edge as a failing result takes priority over the increment.
            if (clear_count) begin
                fault_count <= '0;
            end else if ((state == UNLOAD) && cnt_zero && (resp_next != exp_lat) &&
                         (fault_count != '1)) begin
                fault_count <= fault_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        pat_sr      <= pattern << 1;
                        exp_lat     <= expected;
                        scan_enable <= 1'b1;
                        scan_in     <= pattern[CHAIN_LEN-1];
                        busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt_zero) begin
                        state       <= CAPTURE;
                        scan_enable <= 1'b0;
                        scan_in     <= 1'b0;
                    end else begin
                        scan_in <= pat_sr[CHAIN_LEN-1];
                        pat_sr  <= pat_sr << 1;
                    end
                end
                CAPTURE: begin
                    state       <= UNLOAD;
                    scan_enable <= 1'b1;
                end
                UNLOAD: begin
                    response <= resp_next;
                    if (cnt_zero) begin
                        state       <= DONE;
                        scan_enable <= 1'b0;
                        done        <= 1'b1;
                        pass        <= (resp_next == exp_lat);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_test_controller.sv
// Drives the controller against a two-flop scan chain whose capture logic is a 3-state FSM.
module tb_scan_test_controller;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] expected = '0;
    logic         clear_count = 1'b0;
    logic         scan_out;
    logic         scan_enable;
    logic         scan_in;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic         pass;
    logic [7:0]   fault_count;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;
    logic last_pass = 1'b0;

    // Circuit under test: two scan flops, flop 1 output optionally stuck-at-0.
    logic [N-1:0] chain = '0;
    logic         stuck = 1'b0;
    logic         f1;

    always #5 clk = ~clk;

    function automatic logic [1:0] ns(input logic [1:0] s);
        case (s)
            2'b00:   ns = 2'b01;
            2'b01:   ns = 2'b10;
            default: ns = 2'b00;
        endcase
    endfunction

    assign f1       = stuck ? 1'b0 : chain[1];
    assign scan_out = f1;

    always @(posedge clk) begin
        if (scan_enable) chain <= {chain[0], scan_in};
        else             chain <= ns({f1, chain[0]});
    end

    scan_test_controller #(.CHAIN_LEN(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pattern     (pattern),
        .expected    (expected),
        .clear_count (clear_count),
        .scan_out    (scan_out),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .busy        (busy),
        .done        (done),
        .response    (response),
        .pass        (pass),
        .fault_count (fault_count)
    );

    // Runs one pattern; start is high in cycle 0, done is expected in cycle 2N+2.
    task automatic run_pattern(input logic [1:0] pat, input logic [1:0] exp_v,
                               input logic stk, input logic clr, input string tag);
        logic [1:0] resp_m;
        logic       pass_m;
        logic       se_m, si_m;
        int         old_cnt, new_cnt;
        resp_m  = stk ? 2'b00 : ns(pat);
        pass_m  = (resp_m == exp_v);
        old_cnt = model_cnt;
        if (clr)          new_cnt = 0;
        else if (!pass_m) new_cnt = (old_cnt < 255) ? old_cnt + 1 : 255;
        else              new_cnt = old_cnt;
        @(negedge clk);
        stuck = stk; start = 1'b1; pattern = pat; expected = exp_v;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 2*N+2; c++) begin
            if (c > 1) @(negedge clk);
            se_m = (c <= N) || ((c >= N+2) && (c <= 2*N+1));
            si_m = (c <= N) ? pat[N-c] : 1'b0;
            checks += 4;
            if (scan_enable !== se_m) begin
                failures++; $display("FAIL %s c%0d scan_enable got %b want %b", tag, c, scan_enable, se_m);
            end
            if (scan_in !== si_m) begin
                failures++; $display("FAIL %s c%0d scan_in got %b want %b", tag, c, scan_in, si_m);
            end
            if (done !== (c == 2*N+2)) begin
                failures++; $display("FAIL %s c%0d done got %b want %b", tag, c, done, (c == 2*N+2));
            end
            if (busy !== 1'b1) begin
                failures++; $display("FAIL %s c%0d busy got %b want 1", tag, c, busy);
            end
            if (c < 2*N+2) begin
                checks++;
                if (fault_count !== 8'(old_cnt)) begin
                    failures++; $display("FAIL %s c%0d fault_count got %0d want %0d", tag, c, fault_count, old_cnt);
                end
            end
            if (c == 1) begin
                checks++;
                if (pass !== last_pass) begin
                    failures++; $display("FAIL %s held_pass got %b want %b", tag, pass, last_pass);
                end
            end
            clear_count = (c == 2*N+1) ? clr : 1'b0;
        end
        checks += 3;
        if (pass !== pass_m) begin
            failures++; $display("FAIL %s pass got %b want %b", tag, pass, pass_m);
        end
        if (response !== resp_m) begin
            failures++; $display("FAIL %s response got %b want %b", tag, response, resp_m);
        end
        if (fault_count !== 8'(new_cnt)) begin
            failures++; $display("FAIL %s fault_count got %0d want %0d", tag, fault_count, new_cnt);
        end
        model_cnt = new_cnt;
        last_pass = pass_m;
        stuck = 1'b0;
    endtask

    task automatic clear_counter();
        @(negedge clk); clear_count = 1'b1;
        @(negedge clk); clear_count = 1'b0;
        model_cnt = 0;
        checks++;
        if (fault_count !== 8'd0) begin
            failures++; $display("FAIL clear fault_count got %0d want 0", fault_count);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 7;
        if (scan_enable !== 1'b0) begin failures++; $display("FAIL reset scan_enable got %b want 0", scan_enable); end
        if (scan_in !== 1'b0)     begin failures++; $display("FAIL reset scan_in got %b want 0", scan_in); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL reset busy got %b want 0", busy); end
        if (done !== 1'b0)        begin failures++; $display("FAIL reset done got %b want 0", done); end
        if (pass !== 1'b0)        begin failures++; $display("FAIL reset pass got %b want 0", pass); end
        if (response !== 2'b00)   begin failures++; $display("FAIL reset response got %b want 00", response); end
        if (fault_count !== 8'd0) begin failures++; $display("FAIL reset fault_count got %0d want 0", fault_count); end
        rst_n = 1'b1;
        model_cnt = 0;
        last_pass = 1'b0;
    endtask

    task automatic test_fault_free();
        run_pattern(2'b01, ns(2'b01), 1'b0, 1'b0, "fault_free");
    endtask

    task automatic test_stuck_at();
        run_pattern(2'b01, 2'b10, 1'b1, 1'b0, "stuck_at");
    endtask

    task automatic test_random();
        logic [1:0] p, e;
        logic       s;
        for (int i = 0; i < 24; i++) begin
            p = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 1) == 1) ? ns(p) : 2'($urandom_range(0, 3));
            run_pattern(p, e, s, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int want;
        want = (20 + (2*N+3) - 1) / (2*N+3);
        @(negedge clk);
        start = 1'b1; pattern = 2'b01; expected = ns(2'b01); stuck = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 20) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (pass !== 1'b1) begin failures++; $display("FAIL held_start pass got %b want 1", pass); end
            end
        end
        checks += 2;
        if (dones != want) begin
            failures++; $display("FAIL held_start done_cycles got %0d want %0d", dones, want);
        end
        if (fault_count !== 8'(model_cnt)) begin
            failures++; $display("FAIL held_start fault_count got %0d want %0d", fault_count, model_cnt);
        end
        last_pass = 1'b1;
    endtask

    task automatic test_reset_unload();
        clear_counter();
        @(negedge clk);
        start = 1'b1; pattern = 2'b10; expected = 2'b11;
        @(negedge clk);
        start = 1'b0;
        repeat (N+1) @(negedge clk);
        checks++;
        if (scan_enable !== 1'b1) begin
            failures++; $display("FAIL rst_unload pre scan_enable got %b want 1", scan_enable);
        end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (scan_enable !== 1'b0) begin failures++; $display("FAIL rst_unload scan_enable got %b want 0", scan_enable); end
        if (busy !== 1'b0)        begin failures++; $display("FAIL rst_unload busy got %b want 0", busy); end
        if (done !== 1'b0)        begin failures++; $display("FAIL rst_unload done got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 3;
            if (done !== 1'b0) begin failures++; $display("FAIL rst_unload late_done got %b want 0", done); end
            if (busy !== 1'b0) begin failures++; $display("FAIL rst_unload late_busy got %b want 0", busy); end
            if (fault_count !== 8'd0) begin failures++; $display("FAIL rst_unload fault_count got %0d want 0", fault_count); end
        end
        last_pass = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] p;
        clear_counter();
        for (int i = 0; i < 256; i++) begin
            p = 2'($urandom_range(0, 3));
            run_pattern(p, ~ns(p), 1'b0, 1'b0, "saturate");
        end
        checks++;
        if (fault_count !== 8'd255) begin
            failures++; $display("FAIL saturate final got %0d want 255", fault_count);
        end
        run_pattern(2'b00, 2'b11, 1'b0, 1'b1, "clear_vs_fail");
        checks++;
        if (fault_count !== 8'd0) begin
            failures++; $display("FAIL clear_vs_fail final got %0d want 0", fault_count);
        end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_random();
        test_back_to_back();
        test_reset_unload();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
